pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-layout inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined CPU. It carries a control field and a data field between two stages under a valid/ready handshake, so stalls propagate cleanly. It also supports a synchronous flush that inserts a bubble with all control bits zeroed. An optional skid buffer registers the upstream ready path to break long stall chains.

## Interface
- CTRL_W, 8: width of control field (RegWrite, MemToReg, write-reg index, …); bit 0 is always RegWrite by convention of the consumers.
- DATA_W, 64: width of data field (ALU result, memory read data, …).
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; kills all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream data field.
- out_valid  output  1  downstream entry present.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_ctrl  output  CTRL_W  held control field.
- out_data  output  DATA_W  held data field.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Main register (M): drives out_*. An entry is written into M when M is empty, or when M is being drained in the same cycle.
- out_ctrl is forced to all-zero whenever out_valid = 0, so a bubble never asserts RegWrite or any other control bit. out_data is not masked; it holds its last value.
- Flush takes priority over every other event. At the edge where flush = 1:
  - all valid bits clear and the held ctrl fields are zeroed;
  - any in_* presented that cycle is dropped, even if in_ready = 1;
  - a concurrent output transfer is still counted as consumed downstream.
- Reset (clr_n = 0, any time, including mid-transfer):
  - out_valid = 0, out_ctrl = 0, out_data = 0, skid cleared;
  - in_ready = 0 while clr_n is low, 1 from the first cycle after release.
- An entry already presented and held stable by upstream is never lost or duplicated except by flush or reset.

## Timing
- Latency: 1 cycle. An entry accepted at edge N appears on out_* after edge N.
- Throughput: 1 entry per cycle with out_ready held high.
- Without skid: in_ready = !out_valid || out_ready, which is a combinational path from out_ready.
- With skid (see Configuration): in_ready is a flop output, equal to !skid_valid. It has no combinational path from out_ready.
- Stall and flush in the same cycle: flush wins, and the stage is empty after the edge.
- Reset deassertion: no transfer can occur on the edge coincident with release.

## Configuration
- PIPE_STAGE_SKID_EN defined: second register S (skid) is compiled in.
  - If M is full, not draining, and an input transfer occurs, the entry goes to S and skid_valid is set. in_ready falls on the next cycle.
  - When M drains and S is valid, S moves to M and skid_valid clears.
  - Ordering is strict FIFO, and the stage holds 2 entries.
- PIPE_STAGE_SKID_EN undefined:
  - single register M;
  - in_ready is combinational as stated under Timing;
  - the stage holds 1 entry.
- The port list is identical in both builds.

## Test plan
- Reset: assert clr_n = 0 mid-stream with out_valid = 1 and out_ctrl = 8'hA5. Required response:
  - immediately out_valid = 0, out_ctrl = 0, out_data = 0;
  - after release, in_ready = 1 on the next cycle.
- Streaming: out_ready = 1, push ctrl 8'h01..8'h10 with data = index on consecutive cycles. Required response: out_* show the same sequence one cycle later, no gaps.
- Stall: hold out_ready = 0 for 3 cycles while pushing entries A, B, C. Required response:
  - no skid: only A is accepted and in_ready = 0 while stalled; A is then delivered, followed by B;
  - skid: A and B are accepted, then in_ready = 0; delivery order is A, B, C;
  - nothing is duplicated.
- Flush: assert flush = 1 with M (and S) full and in_valid = 1. Required response:
  - out_valid = 0 and out_ctrl = 0 on the next cycle;
  - the flush-cycle input never appears downstream.
- Simultaneous events: flush = 1, out_ready = 0, in_valid = 1 in one cycle. Required response: stage empty afterwards, in_ready = 1.
- Bubble masking: drain to empty with a last ctrl of 8'hFF. Required response: out_ctrl = 0 while out_valid = 0, and out_data retains its last value.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register (1-cycle latency) with flush-to-bubble; PIPE_STAGE_SKID_EN adds a skid entry.
// Backpressure: in_ready = !out_valid || out_ready, or a registered !skid_valid when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              r_rdy_en;
  logic              r_m_vld;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic              w_in_xfer;
  logic              w_m_free;

  // Held low through reset and the release edge so nothing transfers there.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  assign w_m_free  = !r_m_vld || out_ready;
  assign w_in_xfer = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              r_s_vld;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;

  assign in_ready = r_rdy_en && !r_s_vld;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_m_vld  <= 1'b0;
      r_m_ctrl <= '0;
      r_m_data <= '0;
      r_s_vld  <= 1'b0;
      r_s_ctrl <= '0;
      r_s_data <= '0;
    end else if (flush) begin
      r_m_vld  <= 1'b0;
      r_m_ctrl <= '0;
      r_s_vld  <= 1'b0;
      r_s_ctrl <= '0;
    end else if (w_m_free) begin
      // Skid holds the older entry, so it refills M first; in_ready is low then.
      if (r_s_vld) begin
        r_m_vld  <= 1'b1;
        r_m_ctrl <= r_s_ctrl;
        r_m_data <= r_s_data;
        r_s_vld  <= 1'b0;
      end else if (w_in_xfer) begin
        r_m_vld  <= 1'b1;
        r_m_ctrl <= in_ctrl;
        r_m_data <= in_data;
      end else begin
        r_m_vld  <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_s_vld  <= 1'b1;
      r_s_ctrl <= in_ctrl;
      r_s_data <= in_data;
    end
  end
`else
  assign in_ready = r_rdy_en && w_m_free;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_m_vld  <= 1'b0;
      r_m_ctrl <= '0;
      r_m_data <= '0;
    end else if (flush) begin
      r_m_vld  <= 1'b0;
      r_m_ctrl <= '0;
    end else if (w_in_xfer) begin
      r_m_vld  <= 1'b1;
      r_m_ctrl <= in_ctrl;
      r_m_data <= in_data;
    end else if (out_ready) begin
      r_m_vld  <= 1'b0;
    end
  end
`endif

  assign out_valid = r_m_vld;
  assign out_ctrl  = r_m_vld ? r_m_ctrl : '0;
  assign out_data  = r_m_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue reference model checked every cycle, directed scenarios, random traffic.
// Build with PIPE_STAGE_SKID_EN defined to exercise the two-entry variant.
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ctrl;
  logic [63:0] out_data;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64)) dut (
    .clk(clk), .clr_n(clr_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
  );

  typedef struct packed { logic [7:0] c; logic [63:0] d; } ent_t;

  int          vecs = 0;
  int          fails = 0;
  bit          cmp_en = 1'b0;
  ent_t        q[$];
  bit          rst_done = 1'b0;
  logic [63:0] last_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stage capacity is 1 or 2; without skid a draining full stage can take a new entry.
  function automatic logic m_in_ready();
    if (!rst_done || !clr_n) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q.delete();
      rst_done = 1'b0;
      last_data = '0;
    end else begin
      bit   in_x;
      ent_t e;
      in_x = in_valid && m_in_ready();
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_x) begin
          e.c = in_ctrl;
          e.d = in_data;
          q.push_back(e);
        end
      end
      if (q.size() != 0) last_data = q[0].d;
      rst_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("out_ctrl", 64'(out_ctrl), (q.size() != 0) ? 64'(q[0].c) : 64'd0);
      chk("out_data", out_data, (q.size() != 0) ? q[0].d : last_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [63:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  ent_t        abc[3];
  ent_t        got_e[3];
  int          idx, got, acc_stall;

  initial begin
    tick();
    tick();
    cmp_en = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    clr_n = 1'b1;
    tick();
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Streaming, one per cycle
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i), 64'(i));
      #1 chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_ctrl", 64'(out_ctrl), 64'(i));
      chk("stream_data", out_data, 64'(i));
    end
    in_valid = 1'b0;
    tick();

    // Stall with A, B, C
    abc[0] = '{c: 8'h0A, d: 64'hAAAA};
    abc[1] = '{c: 8'h0B, d: 64'hBBBB};
    abc[2] = '{c: 8'h0C, d: 64'hCCCC};
    idx = 0; got = 0; acc_stall = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin in_ctrl = abc[idx].c; in_data = abc[idx].d; end
      #1;
      if (in_valid && in_ready) begin idx++; acc_stall++; end
      tick();
    end
    chk("stall_accepted", 64'(acc_stall), SKID ? 64'd2 : 64'd1);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin in_ctrl = abc[idx].c; in_data = abc[idx].d; end
      #1;
      if (out_valid && out_ready) begin
        got_e[got].c = out_ctrl;
        got_e[got].d = out_data;
        got++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    chk("stall_delivered", 64'(got), 64'd3);
    for (int k = 0; k < got; k++) begin
      chk("stall_order_ctrl", 64'(got_e[k].c), 64'(abc[k].c));
      chk("stall_order_data", got_e[k].d, abc[k].d);
    end
    in_valid = 1'b0;
    tick();
    chk("stall_drained", 64'(out_valid), 64'd0);

    // Flush with stage full and an input presented
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(8'h30 + 8'(k), 64'h300 + 64'(k));
      #1;
      if (!in_ready) break;
      tick();
    end
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    push(8'h77, 64'h7777);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_leak", 64'(out_valid), 64'd0);
    end

    // Flush drops input even when in_ready is high
    push(8'h41, 64'h4141);
    tick();
    push(8'h88, 64'h8888);
    flush = 1'b1;
    #1 chk("flush2_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_valid", 64'(out_valid), 64'd0);
    tick();
    chk("flush2_no_leak", 64'(out_valid), 64'd0);

    // Flush + stall + input in one cycle
    out_ready = 1'b0;
    push(8'h52, 64'h5252);
    tick();
    flush = 1'b1;
    push(8'h53, 64'h5353);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("simul_valid", 64'(out_valid), 64'd0);
    chk("simul_in_ready", 64'(in_ready), 64'd1);

    // Bubble masking
    out_ready = 1'b1;
    push(8'hFF, 64'hDEAD_BEEF_0123_4567);
    tick();
    in_valid = 1'b0;
    chk("bubble_pre_ctrl", 64'(out_ctrl), 64'hFF);
    tick();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    chk("bubble_data", out_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    chk("bubble_data_hold", out_data, 64'hDEAD_BEEF_0123_4567);

    // Reset mid-stream
    out_ready = 1'b0;
    push(8'hA5, 64'h5A5A);
    tick();
    in_valid = 1'b0;
    chk("prerst_ctrl", 64'(out_ctrl), 64'hA5);
    chk("prerst_valid", 64'(out_valid), 64'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ctrl", 64'(out_ctrl), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    push(8'h66, 64'h6666);
    tick();
    clr_n = 1'b1;
    tick();
    chk("release_no_xfer", 64'(out_valid), 64'd0);
    chk("release2_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ctrl   = 8'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
